// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave side; the host/bench side uses the master modport.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them
// into the instruction memory and holds the core until the image is complete.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W:0]     load_len,
    imem_boot_loader_if.slave   bus,
    output logic                core_hold,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [31:0]         checksum
);
    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [31:0]       full_word;

    // The 4th byte completes the word directly from s_data, so WRITE needs no extra cycle.
    assign full_word = {bus.s_data, word_q[23:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        s_ready_d   = s_ready_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        core_hold_d = core_hold_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (load_len > DEPTH) begin
                        error_d = 1'b1;
                    end else if (load_len == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                        checksum_d  = '0;
                        error_d     = 1'b0;
                    end else begin
                        state_d     = S_RECV;
                        len_d       = load_len;
                        word_idx_d  = '0;
                        byte_cnt_d  = '0;
                        checksum_d  = '0;
                        error_d     = 1'b0;
                        core_hold_d = 1'b1;
                        busy_d      = 1'b1;
                        s_ready_d   = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (bus.s_valid && s_ready_q) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.s_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = S_WRITE;
                        s_ready_d   = 1'b0;
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_idx_q;
                        mem_wdata_d = full_word;
                        checksum_d  = checksum_q ^ full_word;
                    end
                end
            end
            S_WRITE: begin
                if ({1'b0, word_idx_q} == len_q - LEN_ONE) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    state_d    = S_RECV;
                    word_idx_d = word_idx_q + IDX_ONE;
                    byte_cnt_d = '0;
                    s_ready_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            checksum_q  <= checksum_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign core_hold     = core_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign checksum      = checksum_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: loads push expected writes and done
// events into queues, a negedge monitor pops and compares them.
module tb_imem_boot_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              core_hold, busy, done, error;
    logic [31:0]       checksum;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .bus       (bus),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] sum; int cyc; } dn_t;

    wr_t         wq[$];
    dn_t         dq[$];
    logic [31:0] words_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        wr_t ew;
        dn_t ed;
        if (rst_n === 1'b1) begin
            if (bus.mem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%08h expected no write", bus.mem_waddr, bus.mem_wdata);
                end else begin
                    ew = wq.pop_front();
                    check("write_addr", 32'(bus.mem_waddr), 32'(ew.addr));
                    check("write_data", bus.mem_wdata, ew.data);
                    check("hold_during_write", 32'(core_hold), 32'd1);
                end
            end
            if (done === 1'b1) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 expected 0 at cycle %0d", cyc);
                end else begin
                    ed = dq.pop_front();
                    check("done_checksum", checksum, ed.sum);
                    check("done_core_hold", 32'(core_hold), 32'd0);
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_error", 32'(error), 32'd0);
                    if (ed.cyc >= 0) check("done_latency", 32'(cyc), 32'(ed.cyc));
                end
            end
        end
    end

    // stall: 0 = s_valid held high, 1 = toggled every other cycle, 2 = random
    task automatic run_load(input int stall, input int max_bytes, input bit inj);
        logic [7:0]  bq[$];
        logic [31:0] w;
        logic [31:0] sum;
        int          n, mb, idx, budget, st_cyc;
        bit          hs;
        dn_t         d;
        wr_t         e;
        n   = words_q.size();
        mb  = (max_bytes < 0) ? 4 * n : max_bytes;
        sum = '0;
        foreach (words_q[i]) begin
            w = words_q[i];
            for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
            sum ^= w;
            if (4 * (i + 1) <= mb) begin
                e.addr = i;
                e.data = w;
                wq.push_back(e);
            end
        end
        @(posedge clk); #1;
        start    = 1'b1;
        load_len = (ADDR_W + 1)'(n);
        st_cyc   = cyc;
        if (mb >= 4 * n) begin
            d.sum = sum;
            d.cyc = (stall == 0) ? st_cyc + 5 * n + 1 : -1;
            dq.push_back(d);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        idx    = 0;
        budget = 0;
        while (idx < mb && budget < 30000) begin
            bus.s_valid = (stall == 0) ? 1'b1 :
                          (stall == 1) ? budget[0] : 1'($urandom_range(0, 1));
            bus.s_data  = bq[idx];
            start       = inj && (budget == 3);
            if (start) load_len = (ADDR_W + 1)'(1);
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            budget++;
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        check("stream_consumed", 32'(idx), 32'(mb));
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while ((wq.size() != 0 || dq.size() != 0) && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending writes=%0d dones=%0d expected 0", name, wq.size(), dq.size());
            wq.delete();
            dq.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"},   32'(bus.s_ready),   32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_waddr"}, 32'(bus.mem_waddr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "_core_hold"}, 32'(core_hold),     32'd1);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_done"},      32'(done),          32'd0);
        check({tag, "_error"},     32'(error),         32'd0);
        check({tag, "_checksum"},  checksum,           32'd0);
    endtask

    task automatic random_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        load_len    = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Oversized length is rejected and leaves the core held
        @(posedge clk); #1;
        start    = 1'b1;
        load_len = (ADDR_W + 1)'(1025);
        @(posedge clk); #1;
        start = 1'b0;
        check("badlen_error", 32'(error), 32'd1);
        check("badlen_busy", 32'(busy), 32'd0);
        check("badlen_core_hold", 32'(core_hold), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("badlen_still_idle", 32'(bus.s_ready), 32'd0);
        check("badlen_error_sticky", 32'(error), 32'd1);

        random_words(1);
        run_load(0, -1, 1'b0);
        check("error_cleared", 32'(error), 32'd0);
        drain("len1");

        words_q = '{32'h12345678, 32'hDEADBEEF};
        run_load(0, -1, 1'b0);
        drain("two_words");
        check("two_words_checksum", checksum, 32'hCC99E897);
        check("idle_core_hold_low", 32'(core_hold), 32'd0);

        run_load(1, -1, 1'b0);
        drain("stalled");
        check("stalled_checksum", checksum, 32'hCC99E897);

        words_q.delete();
        run_load(0, -1, 1'b0);
        drain("zero_len");

        random_words(3);
        run_load(0, -1, 1'b1);
        drain("start_while_busy");

        for (int r = 0; r < 6; r++) begin
            random_words(int'($urandom_range(1, 6)));
            run_load(2, -1, 1'b0);
            drain("random");
        end

        // Reset after 6 of 16 bytes: only word 0 should have been written
        random_words(4);
        run_load(0, 6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        check("midreset_pending_writes", 32'(wq.size()), 32'd0);
        wq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        random_words(2);
        run_load(2, -1, 1'b0);
        drain("after_reset");

        words_q.delete();
        for (int i = 0; i < 1024; i++) words_q.push_back(32'h0100_0000 + 32'(i));
        run_load(0, -1, 1'b0);
        drain("full_depth");
        check("full_depth_last_addr", 32'(bus.mem_waddr), 32'd1023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the 1024-word instruction memory of the pipelined RISC-V core.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the memory's single write port and holds the core (core_hold) until the image is fully written.
- Sits between the host/debug byte link and the instruction memory write port. Fetch reads are untouched; the core is held while a load is in progress.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words (1024).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle load request, sampled only in IDLE
- load_len  input  ADDR_W+1  number of 32-bit words to load, latched on accepted start
- s_valid  input  1  byte-stream valid
- s_data  input  8  byte-stream data
- s_ready  output  1  byte accepted when s_valid && s_ready
- mem_we  output  1  instruction memory write enable
- mem_waddr  output  ADDR_W  word address of write
- mem_wdata  output  32  write data
- core_hold  output  1  holds core fetch/PC while high
- busy  output  1  load in progress
- done  output  1  one-cycle pulse on load completion
- error  output  1  sticky: start rejected because load_len > 2**ADDR_W; cleared by next accepted start
- checksum  output  32  XOR of all words written in current/last load

Behaviour:
- Reset state, asynchronous on rst_n low:
  - state=IDLE.
  - s_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0.
  - core_hold=1, busy=0, done=0, error=0, checksum=0.
  - Internal counters are cleared.
- States:
  - IDLE: s_ready=0, busy=0. On start:
    - If load_len > 2**ADDR_W: set error=1 and stay in IDLE. core_hold is unchanged.
    - If load_len == 0: go to DONE. No writes, checksum=0, error=0.
    - Otherwise: latch load_len, clear word_idx, byte_cnt and checksum, set error=0, core_hold=1, busy=1, and go to RECV.
  - RECV: s_ready=1, busy=1.
    - Each handshake places s_data into byte lane byte_cnt, so byte 0 maps to bits [7:0] (little-endian).
    - byte_cnt increments on each handshake.
    - On the 4th byte, go to WRITE. s_ready is registered low in WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_waddr=word_idx, mem_wdata=assembled word, s_ready=0.
    - checksum ^= word.
    - If word_idx == len-1, go to DONE. Otherwise word_idx++, byte_cnt=0, and go to RECV.
  - DONE: exactly one cycle.
    - done=1, busy=0, core_hold=0.
    - Go to IDLE next cycle. core_hold stays 0 in IDLE until the next accepted start.
- Timing and outputs:
  - mem_we, mem_waddr and mem_wdata are registered outputs, valid in the WRITE cycle. mem_we is 0 in all other states.
  - Throughput with s_valid held high: 5 cycles per word (4 RECV + 1 WRITE).
  - Total time from start to the done pulse for N words: 1 + 5N cycles.
- Stream stalls: s_valid low in RECV simply waits. There is no timeout, and partial-word bytes are retained.
- start while busy (RECV/WRITE/DONE): ignored, with no effect on error.
- A load of 2**ADDR_W words writes addresses 0..2**ADDR_W-1. mem_waddr never wraps past the last word.
- Reset mid-load: return immediately to IDLE with core_hold=1. Words already written remain in memory, and the partial word is discarded.
- checksum holds its final value after done until the next accepted start.

Test Plan:
- Load 2 words: rst_n released, start with load_len=2, bytes 78 56 34 12 EF BE AD DE streamed with s_valid high.
  - mem_we pulses at word addr 0 with 0x12345678 and at addr 1 with 0xDEADBEEF.
  - done pulses at cycle 11 after start.
  - checksum=0xCC99E897; core_hold 1→0 coincident with done.
- Stalled stream: same load with s_valid toggled low every other cycle.
  - Identical writes, data and checksum.
  - No handshake is counted while s_valid=0.
- Bad length: start with load_len=1025 (ADDR_W=10).
  - error=1, state stays IDLE, no mem_we, core_hold stays 1.
  - A following valid start with load_len=1 clears error.
- Zero length and start-while-busy:
  - load_len=0 gives done one cycle after start, with no writes and core_hold=0.
  - A start issued during RECV of a 3-word load is ignored; exactly 3 writes occur.
- Reset mid-load: assert rst_n low after 6 bytes of a 4-word load.
  - All outputs return to reset values asynchronously, with core_hold=1.
  - Only addr 0 was written. A new load then proceeds normally.
- Full depth: load_len=1024 with an incrementing-word pattern.
  - The last write is at addr 1023, with no wrap to 0.
  - done occurs 5121 cycles after start; checksum matches the XOR of the pattern.
